// File: rtl/pipe_hazard_ctl.sv
// rtl/pipe_hazard_ctl.sv - stall/flush/bubble controller for an in-order pipeline
// Stage 0 is fetch (youngest); stage NSTAGE-1 is the oldest.
module pipe_hazard_ctl #(
    parameter int NSTAGE     = 5,
    parameter int HOLD_STAGE = 3,
    parameter int LENW       = 4,
    parameter int CNTW       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSTAGE-1:0] i_stall_req,
    input  logic [NSTAGE-1:0] i_flush_req,
    input  logic              i_hold_start,
    input  logic [LENW-1:0]   i_hold_len,
    input  logic              i_fetch_val,
    output logic [NSTAGE-1:0] o_stall,
    output logic [NSTAGE-1:0] o_flush,
    output logic [NSTAGE-1:0] o_valid,
    output logic              o_hold_busy,
    output logic [CNTW-1:0]   o_stall_cnt,
    output logic [CNTW-1:0]   o_flush_cnt
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t            r_state;
    logic [LENW-1:0]   r_hold_cnt;
    logic [NSTAGE-1:0] r_valid;
    logic [CNTW-1:0]   r_stall_cnt;
    logic [CNTW-1:0]   r_flush_cnt;

    logic [NSTAGE-1:0] w_older_freq;
    logic [NSTAGE-1:0] w_stall_raw;
    logic [NSTAGE-1:0] w_stalled_by_older;
    logic [NSTAGE-1:0] w_flush_hon;
    logic [NSTAGE-1:0] w_kill;
    logic [NSTAGE-1:0] w_flush;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_valid_in;
    logic              w_hold_busy;

    assign w_hold_busy = (r_state == S_HOLD);

    // Older requests dominate: scan from the oldest stage down to fetch.
    always_comb begin
        logic v_fr_acc;
        logic v_st_acc;
        logic v_kill_acc;
        logic v_s;
        v_fr_acc           = 1'b0;
        v_st_acc           = 1'b0;
        v_kill_acc         = 1'b0;
        v_s                = 1'b0;
        w_older_freq       = '0;
        w_stall_raw        = '0;
        w_stalled_by_older = '0;
        w_flush_hon        = '0;
        w_kill             = '0;
        w_flush            = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            w_older_freq[i] = v_fr_acc;
            v_fr_acc        = v_fr_acc | i_flush_req[i];
            v_s = (i_stall_req[i] | ((i == HOLD_STAGE) && w_hold_busy)) & ~w_older_freq[i];
            w_stalled_by_older[i] = v_st_acc;
            w_stall_raw[i]        = v_st_acc | v_s;
            v_st_acc              = w_stall_raw[i];
            w_flush_hon[i]        = i_flush_req[i] & ~w_stalled_by_older[i];
            w_kill[i]             = v_kill_acc;
            v_kill_acc            = v_kill_acc | w_flush_hon[i];
        end
        for (int i = 0; i < NSTAGE; i++) begin
            w_flush[i] = reset | w_kill[i];
        end
        // Bubble into the oldest stage that is not frozen behind a stall.
        for (int i = 1; i < NSTAGE; i++) begin
            w_flush[i] = w_flush[i] | (w_stall_raw[i-1] & ~w_stall_raw[i]);
        end
    end

    assign w_stall    = w_stall_raw & ~w_flush;
    assign w_valid_in = {r_valid[NSTAGE-2:0], i_fetch_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_hold_start && (i_hold_len != '0) && !w_older_freq[HOLD_STAGE]) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= i_hold_len;
                    end
                end
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt - LENW'(1);
                    if (w_older_freq[HOLD_STAGE] || (r_hold_cnt == LENW'(1))) begin
                        r_state    <= S_IDLE;
                        r_hold_cnt <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            for (int i = 0; i < NSTAGE; i++) begin
                if (w_flush[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (!w_stall[i]) begin
                    r_valid[i] <= w_valid_in[i];
                end
            end
            if (w_stall[0] && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
            if ((|w_flush_hon) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNTW'(1);
            end
        end
    end

    assign o_stall     = w_stall;
    assign o_flush     = w_flush;
    assign o_valid     = r_valid;
    assign o_hold_busy = w_hold_busy;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// tb/tb_pipe_hazard_ctl.sv - scoreboard bench for pipe_hazard_ctl
module tb_pipe_hazard_ctl;

    localparam int NSTAGE = 5;
    localparam int CNTW   = 4;

    localparam logic [5:0] E_ST = 6'b000001;
    localparam logic [5:0] E_FL = 6'b000010;
    localparam logic [5:0] E_VA = 6'b000100;
    localparam logic [5:0] E_HB = 6'b001000;
    localparam logic [5:0] E_SC = 6'b010000;
    localparam logic [5:0] E_FC = 6'b100000;
    localparam logic [5:0] E_ALL = 6'b111111;

    typedef struct {
        string      name;
        logic [5:0] en;
        logic [4:0] st;
        logic [4:0] fl;
        logic [4:0] va;
        logic       hb;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NSTAGE-1:0] stall_req;
    logic [NSTAGE-1:0] flush_req;
    logic              hold_start;
    logic [3:0]        hold_len;
    logic              fetch_val;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic [NSTAGE-1:0] valid;
    logic              hold_busy;
    logic [CNTW-1:0]   stall_cnt;
    logic [CNTW-1:0]   flush_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_hazard_ctl #(.NSTAGE(NSTAGE), .HOLD_STAGE(3), .LENW(4), .CNTW(CNTW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_stall_req  (stall_req),
        .i_flush_req  (flush_req),
        .i_hold_start (hold_start),
        .i_hold_len   (hold_len),
        .i_fetch_val  (fetch_val),
        .o_stall      (stall),
        .o_flush      (flush),
        .o_valid      (valid),
        .o_hold_busy  (hold_busy),
        .o_stall_cnt  (stall_cnt),
        .o_flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input string f, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
        end
    endtask

    task automatic drive(input logic rst, input logic [4:0] sr, input logic [4:0] fr,
                         input logic hs, input logic [3:0] hl, input logic fv);
        @(posedge clk);
        #1;
        reset      = rst;
        stall_req  = sr;
        flush_req  = fr;
        hold_start = hs;
        hold_len   = hl;
        fetch_val  = fv;
    endtask

    task automatic push_exp(input string n, input logic [5:0] en, input logic [4:0] st,
                            input logic [4:0] fl, input logic [4:0] va, input logic hb,
                            input logic [3:0] sc, input logic [3:0] fc);
        exp_t e;
        e.name = n; e.en = en; e.st = st; e.fl = fl; e.va = va;
        e.hb = hb; e.sc = sc; e.fc = fc;
        q.push_back(e);
    endtask

    // Monitor: one expectation is consumed per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.en[0]) check(e.name, "stall", 8'(stall), 8'(e.st));
            if (e.en[1]) check(e.name, "flush", 8'(flush), 8'(e.fl));
            if (e.en[2]) check(e.name, "valid", 8'(valid), 8'(e.va));
            if (e.en[3]) check(e.name, "hold_busy", 8'(hold_busy), 8'(e.hb));
            if (e.en[4]) check(e.name, "stall_cnt", 8'(stall_cnt), 8'(e.sc));
            if (e.en[5]) check(e.name, "flush_cnt", 8'(flush_cnt), 8'(e.fc));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [4:0] fill_va [5];
        fill_va[0] = 5'h00; fill_va[1] = 5'h01; fill_va[2] = 5'h03;
        fill_va[3] = 5'h07; fill_va[4] = 5'h0f;
        reset = 1'b1; stall_req = '0; flush_req = '0;
        hold_start = 1'b0; hold_len = '0; fetch_val = 1'b0;

        // Reset and pipeline fill
        drive(1, 0, 0, 0, 0, 0); push_exp("rst_a", E_ST | E_FL, 0, 5'h1f, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0); push_exp("rst_b", E_ALL, 0, 5'h1f, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0, 1); push_exp("fill", E_ST | E_FL | E_VA, 0, 0, fill_va[k], 0, 0, 0);
        end

        // Load-use stall at stage 2 with bubble into stage 3
        drive(0, 5'b00100, 0, 0, 0, 1); push_exp("stall2", E_ALL, 5'h07, 5'h08, 5'h1f, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);        push_exp("stall2_post", E_ALL, 0, 0, 5'h17, 0, 1, 0);

        // Redirect at stage 2 kills stages 0..1 and masks the younger stall
        drive(0, 5'b00010, 5'b00100, 0, 0, 1); push_exp("flush2", E_ALL, 0, 5'h03, 5'h0f, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);               push_exp("flush2_post", E_ALL, 0, 0, 5'h1c, 0, 1, 1);

        // Hold of 3 cycles; restart during HOLD is ignored; hold_len=0 ignored
        drive(0, 0, 0, 1, 3, 0); push_exp("hold3_start", E_ST | E_FL | E_HB | E_SC, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0); push_exp("hold3_c1", E_ST | E_FL | E_HB, 5'h0f, 5'h10, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 5, 0); push_exp("hold3_c2", E_ST | E_FL | E_HB, 5'h0f, 5'h10, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0); push_exp("hold3_c3", E_ST | E_FL | E_HB, 5'h0f, 5'h10, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0); push_exp("hold3_end", E_ALL & ~E_VA, 0, 0, 0, 0, 4, 1);
        drive(0, 0, 0, 1, 0, 0); push_exp("hold0", E_ST | E_FL | E_HB, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); push_exp("hold0_post", E_ST | E_FL | E_HB | E_SC, 0, 0, 0, 0, 4, 0);

        // Hold aborted by an older redirect
        drive(0, 0, 0, 1, 8, 0);        push_exp("hold8_start", E_HB, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);        push_exp("hold8_c1", E_ST | E_FL | E_HB, 5'h0f, 5'h10, 0, 1, 0, 0);
        drive(0, 0, 5'b10000, 0, 0, 0); push_exp("hold8_abort", E_ALL & ~E_VA, 0, 5'h0f, 0, 1, 5, 1);
        drive(0, 0, 0, 0, 0, 0);        push_exp("hold8_idle", E_ALL & ~E_VA, 0, 0, 0, 0, 5, 2);

        // Redirect from a stage frozen by an older stall is not honoured
        drive(0, 5'b01000, 5'b00010, 0, 0, 0); push_exp("flush_masked", E_ALL & ~E_VA, 5'h0f, 5'h10, 0, 0, 5, 2);
        drive(0, 0, 0, 0, 0, 0);               push_exp("flush_masked_post", E_ALL & ~E_VA, 0, 0, 0, 0, 6, 2);

        // Reset in the middle of a hold
        drive(0, 0, 0, 1, 8, 0); push_exp("rhold_start", E_HB, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); push_exp("rhold_c1", E_ST | E_HB, 5'h0f, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0); push_exp("rhold_reset", E_ST | E_FL, 0, 5'h1f, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); push_exp("rhold_after", E_ALL, 0, 0, 0, 0, 0, 0);

        // Fetch stall long enough to saturate the 4-bit counter
        for (int k = 1; k <= 21; k++) begin
            drive(0, 5'b00001, 0, 0, 0, 0);
            push_exp("sat", E_ST | E_FL | E_SC, 5'h01, 5'h02, 0, 0, (k - 1 > 15) ? 4'd15 : 4'(k - 1), 0);
        end
        drive(0, 0, 0, 0, 0, 0); push_exp("sat_end", E_ST | E_FL | E_SC | E_FC, 0, 0, 0, 0, 15, 0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
